// File: rtl/conv_stream_controller_pkg.sv
// Shared constants for the convolution stream controller: pixel/word geometry
// and the default row width in 32-bit words, plus a counter-width helper.
package conv_stream_controller_pkg;

  localparam int unsigned PIXEL_W           = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned PIXELS_PER_WORD   = WORD_W / PIXEL_W;
  localparam int unsigned IMG_WIDTH         = 320;
  localparam int unsigned ADDRESSES_PER_ROW = IMG_WIDTH / PIXELS_PER_WORD;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_stream_controller_register.sv
// Plain register with asynchronous active-low clear.
// Ports: clk, rst_n, i_d (next value), o_q (registered value).
module conv_stream_controller_register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q <= '0;
    else        o_q <= i_d;
  end

endmodule

// File: rtl/conv_stream_controller.sv
// Streams one frame from the source RAM through the convolution datapath and
// writes the results to the destination RAM, then pulses done.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, pause                       frame request, issue stall
//   busy, done                         frame in progress, end-of-frame pulse
//   src_rd_en/src_rd_addr/src_rd_data  source RAM read port (1-cycle latency)
//   conv_clk_en/conv_input_data        datapath enable and input word
//   conv_output_data                   datapath result (valid after an enable)
//   dst_wr_en/dst_wr_addr/dst_wr_data  destination RAM write port
module conv_stream_controller
  import conv_stream_controller_pkg::*;
#(
  parameter int unsigned WORDS_PER_ROW = ADDRESSES_PER_ROW,
  parameter int unsigned ROWS          = 240,
  parameter int unsigned PIPE_LAT      = WORDS_PER_ROW + 1,
  parameter int unsigned ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [WORD_W-1:0] src_rd_data,
  output logic              conv_clk_en,
  output logic [WORD_W-1:0] conv_input_data,
  input  logic [WORD_W-1:0] conv_output_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [WORD_W-1:0] dst_wr_data
);

  localparam int unsigned TOTAL    = WORDS_PER_ROW * ROWS;
  localparam int unsigned FLUSH_N  = PIPE_LAT - 1;
  localparam int unsigned EN_TOTAL = TOTAL + FLUSH_N;
  localparam int unsigned N_W      = cnt_width(EN_TOTAL);
  localparam int unsigned FL_W     = cnt_width(FLUSH_N);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [FL_W-1:0]   r_fl_cnt;
  logic [N_W-1:0]    r_en_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_src_rd_en;
  logic [ADDR_W-1:0] r_src_rd_addr;
  logic              r_flush_en;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              w_conv_en;
  logic              w_dly_read;
  logic [N_W-1:0]    w_n_next;

  // Frame sequencer: issues read addresses, then zero flush words, then waits
  // for the final write before pulsing done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd_cnt      <= '0;
      r_fl_cnt      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_src_rd_en   <= 1'b0;
      r_src_rd_addr <= '0;
      r_flush_en    <= 1'b0;
    end else begin
      r_src_rd_en <= 1'b0;
      r_flush_en  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_READ;
            r_busy   <= 1'b1;
            r_rd_cnt <= '0;
            r_fl_cnt <= '0;
          end
        end
        S_READ: begin
          if (!pause) begin
            r_src_rd_en   <= 1'b1;
            r_src_rd_addr <= r_rd_cnt;
            r_rd_cnt      <= r_rd_cnt + ADDR_W'(1);
            if (r_rd_cnt == ADDR_W'(TOTAL - 1))
              r_state <= (FLUSH_N == 0) ? S_DRAIN : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!pause) begin
            r_flush_en <= 1'b1;
            r_fl_cnt   <= r_fl_cnt + FL_W'(1);
            if (r_fl_cnt == FL_W'(FLUSH_N - 1))
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // In-flight words keep draining even while paused.
          if (r_wr_en && (r_wr_addr == ADDR_W'(TOTAL - 1))) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue strobe delayed one cycle so the enable lines up with RAM read data.
  conv_stream_controller_register #(.WIDTH(2)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({r_src_rd_en | r_flush_en, r_src_rd_en}),
    .o_q   ({w_conv_en, w_dly_read})
  );

  assign w_n_next = r_en_cnt + N_W'(1);

  // Enable counter and write-address generation; the first PIPE_LAT-1
  // enables only fill the datapath and produce no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_cnt  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_en_cnt <= '0;
      end else if (w_conv_en) begin
        r_en_cnt <= w_n_next;
        if (w_n_next >= N_W'(PIPE_LAT)) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= ADDR_W'(w_n_next - N_W'(PIPE_LAT));
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign src_rd_en   = r_src_rd_en;
  assign src_rd_addr = r_src_rd_addr;
  assign conv_clk_en = w_conv_en;
  assign dst_wr_en   = r_wr_en;
  assign dst_wr_addr = r_wr_addr;
  // Data buses pass through in the same cycle as their strobe (RAM read data
  // and datapath result are only valid then); masked to zero otherwise.
  assign conv_input_data = w_dly_read ? src_rd_data : '0;
  assign dst_wr_data     = r_wr_en ? conv_output_data : '0;

endmodule

// File: tb/tb_conv_stream_controller.sv
// Scoreboard bench for conv_stream_controller: stimulus pushes expected reads,
// datapath inputs, writes and done latency; a negedge monitor pops and compares.
module tb_conv_stream_controller;

  localparam int unsigned TOT = 12;
  localparam int unsigned FLN = 4;
  localparam int unsigned AW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          busy, done;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [31:0]   src_rd_data = '0;
  logic          conv_clk_en;
  logic [31:0]   conv_input_data;
  logic [31:0]   conv_output_data;
  logic          dst_wr_en;
  logic [AW-1:0] dst_wr_addr;
  logic [31:0]   dst_wr_data;

  conv_stream_controller #(
    .WORDS_PER_ROW(4), .ROWS(3), .PIPE_LAT(5), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .conv_clk_en(conv_clk_en), .conv_input_data(conv_input_data),
    .conv_output_data(conv_output_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
  );

  always #5 clk = ~clk;

  logic [31:0] src_mem [TOT] = '{32'h11223344, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF,
                                 32'h80000000, 32'h12345678, 32'hCAFEF00D, 32'h0F0F0F0F,
                                 32'hF0F0F0F0, 32'h55AA55AA, 32'h01020304, 32'h7FFFFFFF};
  logic [31:0] dst_mem [TOT];
  logic [31:0] pipe [5];
  logic        dst_clr = 1'b0;

  // Source RAM, 1-cycle read latency.
  always @(posedge clk)
    if (src_rd_en)
      src_rd_data <= (src_rd_addr < AW'(TOT)) ? src_mem[src_rd_addr[3:0]] : 32'hBAD0BAD0;

  // Datapath model: input word of enable m appears after enable m+4.
  always @(posedge clk)
    if (conv_clk_en) begin
      pipe[0] <= conv_input_data;
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  assign conv_output_data = pipe[4];

  // Destination RAM.
  always @(posedge clk)
    if (dst_clr) begin
      for (int i = 0; i < int'(TOT); i++) dst_mem[i] <= 32'h0;
    end else if (dst_wr_en && dst_wr_addr < AW'(TOT)) begin
      dst_mem[dst_wr_addr[3:0]] <= dst_wr_data;
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int rd_seen, en_seen, wr_seen, done_seen, en5_cyc, t0;
  int          exp_rd_q[$];
  logic [31:0] exp_cin_q[$];
  int          exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  int          exp_done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic bad(input string name);
    n_chk++;
    $display("FAIL %s: unexpected event at t=%0t", name, $time);
  endtask

  // Monitor: every DUT output event pops and checks the matching expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (src_rd_en) begin
        rd_seen++;
        if (exp_rd_q.size() == 0) bad("rd_extra");
        else chk("rd_addr", 32'(src_rd_addr), 32'(exp_rd_q.pop_front()));
      end
      if (conv_clk_en) begin
        en_seen++;
        if (en_seen == 5) en5_cyc = cyc;
        if (exp_cin_q.size() == 0) bad("conv_en_extra");
        else chk("conv_input_data", conv_input_data, exp_cin_q.pop_front());
      end
      if (dst_wr_en) begin
        wr_seen++;
        if (wr_seen == 1) chk("first_wr_cycle", 32'(cyc), 32'(en5_cyc + 1));
        if (exp_wa_q.size() == 0) bad("wr_extra");
        else begin
          chk("wr_addr", 32'(dst_wr_addr), 32'(exp_wa_q.pop_front()));
          chk("wr_data", dst_wr_data, exp_wd_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done_q.size() == 0) bad("done_extra");
        else chk("done_latency", 32'(cyc - t0), 32'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_src_rd_en"}, 32'(src_rd_en), 32'h0);
    chk({tag, "_conv_clk_en"}, 32'(conv_clk_en), 32'h0);
    chk({tag, "_dst_wr_en"}, 32'(dst_wr_en), 32'h0);
    chk({tag, "_src_rd_addr"}, 32'(src_rd_addr), 32'h0);
    chk({tag, "_dst_wr_addr"}, 32'(dst_wr_addr), 32'h0);
    chk({tag, "_conv_input_data"}, conv_input_data, 32'h0);
    chk({tag, "_dst_wr_data"}, dst_wr_data, 32'h0);
  endtask

  task automatic push_frame(input int done_lat);
    for (int k = 0; k < int'(TOT); k++) begin
      exp_rd_q.push_back(k);
      exp_cin_q.push_back(src_mem[k]);
      exp_wa_q.push_back(k);
      exp_wd_q.push_back(src_mem[k]);
    end
    for (int k = 0; k < int'(FLN); k++) exp_cin_q.push_back(32'h0);
    exp_done_q.push_back(done_lat);
    rd_seen = 0; en_seen = 0; wr_seen = 0; done_seen = 0; en5_cyc = -100;
  endtask

  task automatic issue_start();
    dst_clr = 1'b1;
    @(negedge clk);
    dst_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    #1 chk("busy_after_start", 32'(busy), 32'h1);
  endtask

  task automatic run_frame(input int pause_after, input bit mid_start, input bit start_at_done);
    bit paused_done = 1'b0;
    bit mid_done    = 1'b0;
    int guard       = 0;
    push_frame((pause_after > 0) ? 22 : 19);
    issue_start();
    while (done_seen == 0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
      if (pause_after > 0 && !paused_done && rd_seen == pause_after) begin
        paused_done = 1'b1;
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
      end
      if (mid_start && !mid_done && rd_seen == 3) begin
        mid_done = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (done_seen == 0) bad("frame_timeout");
    if (start_at_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) begin
        #1 chk("busy_after_done_start", 32'(busy), 32'h0);
        @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);
    #1;
    chk("frame_reads", 32'(rd_seen), 32'(TOT));
    chk("frame_enables", 32'(en_seen), 32'(TOT + FLN));
    chk("frame_writes", 32'(wr_seen), 32'(TOT));
    chk("frame_dones", 32'(done_seen), 32'h1);
    chk("busy_idle", 32'(busy), 32'h0);
    chk("queues_empty", 32'(exp_rd_q.size() + exp_cin_q.size() + exp_wa_q.size() + exp_done_q.size()), 32'h0);
    for (int k = 0; k < int'(TOT); k++) chk("dst_ram", dst_mem[k], src_mem[k]);
  endtask

  task automatic reset_mid_frame();
    int guard = 0;
    push_frame(19);
    issue_start();
    while (rd_seen < 7 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (rd_seen < 7) bad("reset_wait_timeout");
    rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_rd_q.delete(); exp_cin_q.delete(); exp_wa_q.delete();
    exp_wd_q.delete(); exp_done_q.delete();
    done_seen = 0; wr_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("post_reset_no_done", 32'(done_seen), 32'h0);
    chk("post_reset_no_write", 32'(wr_seen), 32'h0);
    chk("post_reset_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0, 1'b0);
    run_frame(6, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    reset_mid_frame();
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
